// File: rtl/weapon_fire_scheduler.sv
// Round-robin fire scheduler owning the shared ammo pool: reload, fire, cooldown.
// Optional multi-shot bursts per grant when WEAPONS_BURST_EN is defined.
module weapon_fire_scheduler #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned AW        = 9,
  parameter int unsigned COOLDOWN  = 3,
  parameter int unsigned INIT_AMMO = 0,
  parameter int unsigned BURST_LEN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      mode,
  input  logic [NREQ-1:0] req,
  input  logic [AW-1:0]   rate,
  input  logic            reload_req,
  input  logic [AW-1:0]   max_ammo,
  output logic [NREQ-1:0] grant,
  output logic            fire,
  output logic [AW-1:0]   ammo,
  output logic            busy,
  output logic            error,
  output logic [1:0]      state
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(COOLDOWN + 1);
  localparam logic [3:0]  ATTACK = 4'b0010;

  if (NREQ < 2 || COOLDOWN < 1 || BURST_LEN < 1) begin : g_param_check
    $error("weapon_fire_scheduler: NREQ>=2, COOLDOWN>=1, BURST_LEN>=1 required");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FIRE   = 2'b01,
    COOL   = 2'b10,
    RELOAD = 2'b11
  } state_t;

  state_t        st;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] win_r;
  logic [CW-1:0] cnt;
  logic          found;
  logic          attack;
  logic          legal;
  logic          burst_more;
  logic [AW-1:0] ammo_inc;

  assign attack   = (mode == ATTACK);
  assign legal    = attack && (ammo >= rate);
  assign ammo_inc = (ammo < max_ammo) ? ammo + AW'(1) : ammo;
  assign state    = st;

  // First set request at or above ptr, wrapping modulo NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      logic [PW-1:0] idx;
      idx = PW'((32'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

`ifdef WEAPONS_BURST_EN
  localparam int unsigned BCW = $clog2(BURST_LEN + 1);
  logic [BCW-1:0] bcnt;

  assign burst_more = (bcnt < BCW'(BURST_LEN)) && req[win_r] && attack &&
                      (ammo >= rate) && ((ammo - rate) >= rate);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bcnt <= '0;
    else if (st == IDLE)
      bcnt <= BCW'(1);
    else if (st == FIRE && burst_more)
      bcnt <= bcnt + BCW'(1);
  end
`else
  assign burst_more = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st    <= IDLE;
      ammo  <= AW'(INIT_AMMO);
      ptr   <= '0;
      win_r <= '0;
      cnt   <= '0;
      grant <= '0;
      fire  <= 1'b0;
      error <= 1'b0;
      busy  <= 1'b0;
    end else begin
      error <= 1'b0;
      case (st)
        IDLE: begin
          if (reload_req) begin
            st   <= RELOAD;
            busy <= 1'b1;
          end else if (found && legal) begin
            st    <= FIRE;
            busy  <= 1'b1;
            fire  <= 1'b1;
            grant <= NREQ'(1) << win;
            win_r <= win;
          end else if (found) begin
            error <= 1'b1;
          end
        end
        FIRE: begin
          if (ammo >= rate)
            ammo <= ammo - rate;
          // fire/grant hold through a burst; the pointer moves only once it ends.
          if (!burst_more) begin
            fire  <= 1'b0;
            grant <= '0;
            ptr   <= (win_r == PW'(NREQ - 1)) ? '0 : win_r + PW'(1);
            cnt   <= CW'(COOLDOWN);
            st    <= COOL;
          end
        end
        COOL: begin
          if (cnt <= CW'(1)) begin
            cnt  <= '0;
            st   <= IDLE;
            busy <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RELOAD: begin
          ammo <= ammo_inc;
          if (!reload_req || ammo_inc >= max_ammo) begin
            st   <= IDLE;
            busy <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weapon_fire_scheduler.sv
// Directed testbench for weapon_fire_scheduler; burst scenario follows WEAPONS_BURST_EN.
module tb_weapon_fire_scheduler;
  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [3:0]      mode = '0;
  logic [NREQ-1:0] req = '0;
  logic [AW-1:0]   rate = '0;
  logic            reload_req = 1'b0;
  logic [AW-1:0]   max_ammo = '0;
  logic [NREQ-1:0] grant;
  logic            fire;
  logic [AW-1:0]   ammo;
  logic            busy;
  logic            error;
  logic [1:0]      state;
  logic [8:0]      st_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // {state, busy, fire, error, grant}
  assign st_v = {state, busy, fire, error, grant};

  weapon_fire_scheduler #(
    .NREQ(NREQ), .AW(AW), .COOLDOWN(3), .INIT_AMMO(0), .BURST_LEN(3)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .req(req), .rate(rate),
    .reload_req(reload_req), .max_ammo(max_ammo), .grant(grant), .fire(fire),
    .ammo(ammo), .busy(busy), .error(error), .state(state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse;
    rst = 1'b0;
    tick;
    rst = 1'b1;
  endtask

  task automatic reload_to(input logic [AW-1:0] m);
    bit done;
    done = 1'b0;
    req = '0;
    max_ammo = m;
    reload_req = 1'b1;
    tick;
    for (int i = 0; i < 100 && !done; i++) begin
      tick;
      if (state == 2'b00) done = 1'b1;
    end
    reload_req = 1'b0;
    checks++;
    if (!done || ammo !== m) begin
      errors++;
      $display("FAIL reload_to: ammo=%0d done=%0d want ammo=%0d", ammo, done, m);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick;
    tick;
    checks++;
    if (st_v !== 9'b0) begin errors++; $display("FAIL reset_status: got %b want %b", st_v, 9'b0); end
    checks++;
    if (ammo !== AW'(0)) begin errors++; $display("FAIL reset_ammo: got %0d want 0", ammo); end
  endtask

  task automatic test_reload;
    logic [8:0] exp_v;
    rst = 1'b1;
    max_ammo = AW'(10);
    reload_req = 1'b1;
    tick;
    checks++;
    if (st_v !== 9'b11_1_0_0_0000 || ammo !== AW'(0)) begin
      errors++; $display("FAIL reload_enter: status=%b ammo=%0d want 111000000 ammo=0", st_v, ammo);
    end
    for (int k = 1; k <= 10; k++) begin
      tick;
      exp_v = (k < 10) ? 9'b11_1_0_0_0000 : 9'b0;
      checks++;
      if (ammo !== AW'(k) || st_v !== exp_v) begin
        errors++; $display("FAIL reload_step%0d: ammo=%0d status=%b want ammo=%0d status=%b", k, ammo, st_v, k, exp_v);
      end
    end
    reload_req = 1'b0;
  endtask

  task automatic test_round_robin;
    rate = AW'(5);
    mode = 4'b0010;
    req = 4'b0110;
    tick;
    checks++;
    if (st_v !== 9'b01_1_1_0_0010 || ammo !== AW'(10)) begin
      errors++; $display("FAIL rr_first: status=%b ammo=%0d want 011100010 ammo=10", st_v, ammo);
    end
    tick;
    checks++;
    if (st_v !== 9'b10_1_0_0_0000 || ammo !== AW'(5)) begin
      errors++; $display("FAIL rr_first_dec: status=%b ammo=%0d want 101000000 ammo=5", st_v, ammo);
    end
    for (int k = 0; k < 3; k++) tick;
    checks++;
    if (st_v !== 9'b0) begin errors++; $display("FAIL rr_cool_exit: status=%b want 000000000", st_v); end
    tick;
    checks++;
    if (st_v !== 9'b01_1_1_0_0100 || ammo !== AW'(5)) begin
      errors++; $display("FAIL rr_second: status=%b ammo=%0d want 011100100 ammo=5", st_v, ammo);
    end
    tick;
    checks++;
    if (ammo !== AW'(0)) begin errors++; $display("FAIL rr_empty: ammo=%0d want 0", ammo); end
    for (int k = 0; k < 3; k++) tick;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (st_v !== 9'b00_0_0_1_0000) begin
        errors++; $display("FAIL rr_noammo_err%0d: status=%b want 000010000", k, st_v);
      end
    end
    req = '0;
    tick;
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL rr_err_clear: error=%b want 0", error); end
  endtask

  task automatic test_wrong_mode;
    reload_to(AW'(10));
    mode = 4'b0001;
    rate = AW'(5);
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (fire !== 1'b0 || error !== 1'b1 || ammo !== AW'(10)) begin
        errors++; $display("FAIL wrong_mode%0d: fire=%b error=%b ammo=%0d want 0 1 10", k, fire, error, ammo);
      end
    end
    req = '0;
    tick;
  endtask

  task automatic test_reload_full;
    mode = 4'b0000;
    max_ammo = AW'(8);
    reload_req = 1'b1;
    tick;
    checks++;
    if (state !== 2'b11) begin errors++; $display("FAIL full_enter: state=%b want 11", state); end
    tick;
    checks++;
    if (st_v !== 9'b0 || ammo !== AW'(10)) begin
      errors++; $display("FAIL full_exit: status=%b ammo=%0d want 000000000 ammo=10", st_v, ammo);
    end
    reload_req = 1'b0;
    tick;
  endtask

  task automatic test_reload_interplay;
    mode = 4'b0010;
    rate = AW'(1);
    req = 4'b0001;
    max_ammo = AW'(10);
    reload_req = 1'b1;
    reset_pulse;
    tick;
    checks++;
    if (st_v !== 9'b11_1_0_0_0000) begin errors++; $display("FAIL inter_enter: status=%b want 111000000", st_v); end
    for (int k = 1; k <= 3; k++) begin
      tick;
      checks++;
      if (st_v !== 9'b11_1_0_0_0000 || ammo !== AW'(k)) begin
        errors++; $display("FAIL inter_step%0d: status=%b ammo=%0d want 111000000 ammo=%0d", k, st_v, ammo, k);
      end
    end
    reload_req = 1'b0;
    tick;
    checks++;
    if (st_v !== 9'b0 || ammo !== AW'(4)) begin
      errors++; $display("FAIL inter_exit: status=%b ammo=%0d want 000000000 ammo=4", st_v, ammo);
    end
    tick;
    checks++;
    if (st_v !== 9'b01_1_1_0_0001 || ammo !== AW'(4)) begin
      errors++; $display("FAIL inter_grant: status=%b ammo=%0d want 011100001 ammo=4", st_v, ammo);
    end
    tick;
    checks++;
    if (ammo !== AW'(3)) begin errors++; $display("FAIL inter_dec: ammo=%0d want 3", ammo); end
    req = '0;
    for (int k = 0; k < 3; k++) tick;
  endtask

  task automatic test_zero_rate_reset;
    rate = AW'(0);
    mode = 4'b0010;
    req = 4'b1000;
    reset_pulse;
    tick;
    checks++;
    if (st_v !== 9'b01_1_1_0_1000) begin errors++; $display("FAIL zero_grant: status=%b want 011101000", st_v); end
    tick;
    checks++;
    if (st_v !== 9'b10_1_0_0_0000 || ammo !== AW'(0)) begin
      errors++; $display("FAIL zero_nodec: status=%b ammo=%0d want 101000000 ammo=0", st_v, ammo);
    end
    for (int k = 0; k < 4; k++) tick;
    checks++;
    if (st_v !== 9'b01_1_1_0_1000) begin errors++; $display("FAIL zero_refire: status=%b want 011101000", st_v); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (st_v !== 9'b0 || ammo !== AW'(0)) begin
      errors++; $display("FAIL reset_in_fire: status=%b ammo=%0d want 000000000 ammo=0", st_v, ammo);
    end
    req = '0;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_burst;
    reset_pulse;
    reload_to(AW'(20));
    rate = AW'(5);
    mode = 4'b0010;
    req = 4'b0001;
    tick;
    checks++;
    if (st_v !== 9'b01_1_1_0_0001 || ammo !== AW'(20)) begin
      errors++; $display("FAIL burst_shot1: status=%b ammo=%0d want 011100001 ammo=20", st_v, ammo);
    end
`ifdef WEAPONS_BURST_EN
    for (int k = 2; k <= 3; k++) begin
      tick;
      checks++;
      if (st_v !== 9'b01_1_1_0_0001 || ammo !== AW'(25 - 5 * k)) begin
        errors++; $display("FAIL burst_shot%0d: status=%b ammo=%0d want 011100001 ammo=%0d", k, st_v, ammo, 25 - 5 * k);
      end
    end
    tick;
    req = '0;
    checks++;
    if (st_v !== 9'b10_1_0_0_0000 || ammo !== AW'(5)) begin
      errors++; $display("FAIL burst_end: status=%b ammo=%0d want 101000000 ammo=5", st_v, ammo);
    end
`else
    tick;
    req = '0;
    checks++;
    if (st_v !== 9'b10_1_0_0_0000 || ammo !== AW'(15)) begin
      errors++; $display("FAIL single_shot: status=%b ammo=%0d want 101000000 ammo=15", st_v, ammo);
    end
`endif
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++;
      if (state !== 2'b10) begin errors++; $display("FAIL cool_hold%0d: state=%b want 10", k, state); end
    end
    tick;
    checks++;
    if (st_v !== 9'b0) begin errors++; $display("FAIL cool_done: status=%b want 000000000", st_v); end
  endtask

  initial begin
    test_reset;
    test_reload;
    test_round_robin;
    test_wrong_mode;
    test_reload_full;
    test_reload_interplay;
    test_zero_rate_reset;
    test_burst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weapon_fire_scheduler.md
# weapon_fire_scheduler

Round-robin fire scheduler for the shared ammunition pool of the weapons subsystem. Arbitrates fire requests from up to NREQ turrets, owns the ammunition count, and sequences reload, firing and post-shot cooldown. Sits between the turret/command logic and the weapons datapath. Raises `error` when a shot is requested outside attack mode or with insufficient ammo.

## Interface
- `NREQ`, 4, number of requesting turrets (≥2)
- `AW`, 9, ammo count / rate width
- `COOLDOWN`, 3, idle cycles after a shot before the next grant (≥1)
- `INIT_AMMO`, 0, ammo value on reset
- `BURST_LEN`, 3, max consecutive shots per grant; used only with the configuration macro
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mode`  in  4  operating mode; attack mode = 4'b0010
- `req`  in  NREQ  per-turret fire request, level
- `rate`  in  AW  ammo consumed per shot
- `reload_req`  in  1  reload request, level
- `max_ammo`  in  AW  reload ceiling
- `grant`  out  NREQ  one-hot, the turret being served; high only while `fire` is high
- `fire`  out  1  shot strobe, one per shot
- `ammo`  out  AW  current ammo count
- `busy`  out  1  high when state ≠ IDLE
- `error`  out  1  registered request-violation flag
- `state`  out  2  IDLE=00, FIRE=01, COOL=10, RELOAD=11

## Operation
- Attack mode is asserted when `mode == 4'b0010`.
- A shot is legal when attack mode is set and `ammo >= rate`. A `rate` of 0 is legal and fires without any decrement.
- IDLE:
  - If `reload_req` is high → RELOAD. Reload has priority over `req`.
  - Else if `|req` and the shot is legal → FIRE. The winner is the first set `req` bit scanning upward from `ptr`, wrapping modulo NREQ.
  - Else if `|req` and the shot is illegal → stay in IDLE with `error`=1 next cycle. This repeats every cycle the condition holds.
  - Else stay in IDLE.
- FIRE (one cycle per shot):
  - `fire`=1 and `grant`=one-hot winner.
  - `ammo` ← `ammo − rate`.
  - On exit: `ptr` ← winner+1 mod NREQ, cooldown counter ← COOLDOWN, next state → COOL.
- COOL: counter decrements each cycle; at 1 → IDLE. `req` and `reload_req` are ignored and no error is raised.
- RELOAD:
  - Each cycle: `ammo` ← `ammo+1` if `ammo < max_ammo`.
  - Exit to IDLE when `reload_req` is low, or when `ammo >= max_ammo` after the update.
  - `req` during RELOAD gets no grant and raises no error.
  - If `max_ammo ≤ ammo` on entry, there is no increment and the block exits after one cycle.
- `ammo` never wraps. Subtraction happens only when the shot is legal; increment is capped at `max_ammo`.
- `error` depends only on the IDLE evaluation and is cleared in all other states.
- Reset values: `state`=IDLE, `ammo`=INIT_AMMO, `ptr`=0, cooldown counter=0, `grant`=0, `fire`=0, `error`=0, `busy`=0.
- Reset asserted in any state, including mid-FIRE or mid-RELOAD, forces the reset values immediately. A shot in progress is not counted.

## Timing
- `req`/`mode`/`rate` are sampled in IDLE at edge N. `fire`/`grant` are high in cycle N+1. The decremented `ammo` is visible from cycle N+2.
- Back-to-back shots are spaced by at least 2+COOLDOWN cycles, measured fire to fire.
- `error` is registered: the violating sample at edge N gives `error`=1 in cycle N+1.
- Reload rate is one round per cycle. The first increment is visible one cycle after RELOAD is entered.
- All outputs are driven from registers.

## Configuration
- `WEAPONS_BURST_EN` defined:
  - FIRE stays in FIRE for another shot when all of the following hold: shots this grant < BURST_LEN, the granted `req` bit is still high, attack mode is set, and `ammo − rate ≥ rate`.
  - `fire` stays high for consecutive cycles and `grant` is unchanged.
  - `ptr` advances and COOL is entered only when the burst ends.
- Not defined: exactly one shot per grant, and BURST_LEN is ignored.

## Test plan
- Reload: `rst` deasserted, `max_ammo`=10, `reload_req` held high from IDLE → `ammo` steps 1..10 over 10 cycles, then `state`=IDLE with `busy`=0.
- Round-robin and empty: `ammo`=10, `rate`=5, `mode`=0010, `req`=4'b0110 held →
  - `grant`=0010, `ammo`=5.
  - 5 cycles later `grant`=0100, `ammo`=0.
  - After COOL, IDLE sets `error`=1 each cycle with `grant`=0.
- Wrong mode: `mode`=0001, `ammo`=10, `req`=0001 → `error`=1 every cycle, `fire`=0, `ammo` stays 10.
- Reload interplay: `req`=0001 during RELOAD gives no `fire` and `error`=0. Dropping `reload_req` at `ammo`=4 → IDLE holding 4, then a grant issues.
- Zero rate and reset: `ammo`=0, `rate`=0, `req`=1000 → `fire` with `ammo`=0 unchanged. Asserting `rst` during FIRE → all outputs return to reset values immediately.
- `WEAPONS_BURST_EN`, BURST_LEN=3: `ammo`=20, `rate`=5, `req`=0001 held → `fire` high 3 consecutive cycles, `ammo`=5, then COOL for 3 cycles.
